rv_dmem_responder: RTL and testbench
====================================

# rv_dmem_responder

Synthesizable data-memory slave sitting directly downstream of the core's data port (`data_req_*` / `data_rsp_*`), used as the concrete memory behind simulation and bounded-proof benches of `RV`. It accepts one request per cycle. It applies byte-masked writes to an internal word array. It returns read data in order after a fixed latency, and it buffers up to `DEPTH` outstanding reads.

## Interface
- `MEM_WORDS`, 256: number of 32-bit words. Must be a power of two. The word index is `addr[2 +: log2(MEM_WORDS)]`, and higher address bits are ignored, so addresses alias.
- `LATENCY`, 1: cycles from read acceptance to `data_rsp_valid`. Legal range is 1–8.
- `DEPTH`, 2: maximum outstanding reads. Must be at least 1.
- `clk  in  1`: clock.
- `reset  in  1`: synchronous, active-high reset.
- `data_req_valid  in  1`: request present.
- `data_req_ready  out  1`: request can be accepted this cycle.
- `data_req_wr  in  1`: 1 = write, 0 = read.
- `data_req_addr  in  32`: byte address.
- `data_req_size  in  2`: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `data_req_data  in  32`: write data, lane-aligned.
- `data_rsp_valid  out  1`: one-cycle read response pulse. There is no back-pressure, so the core must take it.
- `data_rsp_data  out  32`: full word read. It is not shifted and not extended.
- `misalign  out  1`: one-cycle error pulse.

## Operation
- Accept condition: `data_req_valid && data_req_ready`.
- `data_req_ready = !reset && (outstanding < DEPTH)`.
- Byte mask: `mask = (((1 << (1 << size)) - 1) << addr[1:0])[3:0]`.
- Legal request: `size != 3`, and either `size == 0`, or `size == 1 && !addr[0]`, or `size == 2 && addr[1:0] == 0`.
- Accepted write, legal:
  - Each byte lane `i` with `mask[i]` is written from `data_req_data[8i+7:8i]` at the accepting clock edge.
  - A write produces no response.
- Accepted write, illegal: the memory is unchanged.
- Accepted read, legal or illegal:
  - The memory word is sampled at acceptance, before any write in that same cycle. Two requests in one cycle are impossible.
  - The sampled word and a countdown of `LATENCY` are pushed into the response queue.
- Any illegal accepted request drives `misalign` = 1 in the following cycle. A read still responds so the core cannot hang.
- Response queue:
  - FIFO ordered.
  - The head pops when its countdown reaches zero; that cycle it drives `data_rsp_valid` = 1 with the head's data.
  - At most one pop per cycle. This is guaranteed because at most one push per cycle occurs and latency is fixed.
- `outstanding` tracks occupancy:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop in the same cycle: unchanged. This is allowed only when `outstanding < DEPTH` before the cycle, because `ready` is evaluated on current occupancy.
- Memory contents are not reset. Benches preload them via hierarchical init, or treat them as unconstrained in proofs.

## Timing
- Reset values:
  - `data_req_ready`: 0.
  - `data_rsp_valid`: 0.
  - `data_rsp_data`: 0.
  - `misalign`: 0.
  - Queue: empty.
  - `outstanding`: 0.
- A read accepted at edge T drives `data_rsp_valid` high during the cycle after edge T+LATENCY−1. That is, with `LATENCY` = 1 the response is visible in the cycle immediately following acceptance.
- A write accepted at edge T is visible to a read accepted at edge T+1 or later.
- When `data_rsp_valid` = 0, `data_rsp_data` holds its last value.
- Full queue: `data_req_ready` = 0 until a pop reduces `outstanding`. `ready` returns to 1 in the cycle after the pop.
- Reset asserted mid-operation:
  - All queued responses are dropped, with no late `rsp_valid`.
  - `misalign` is cleared.
  - Memory contents are retained.

## Structure
- Package `rv_dmem_pkg`:
  - Size encodings: `SZ_B`, `SZ_H`, `SZ_W`.
  - Function `byte_mask(size, addr_lo)`.
  - Function `is_aligned(size, addr_lo)`.
- Sub-module `rv_dmem_rsp_queue`:
  - Parameterized by `DEPTH` and `LATENCY`.
  - Circular buffer of {data, countdown} with head/tail pointers and a count.
  - Exposes `push`, `push_data`, `pop_valid`, `pop_data`, `full`.
- The top level holds the memory array, the decode and mask logic, and the `misalign` register.

## Test plan
- Reset, then preload word 0x10 = 0xAABBCCDD. Read at addr 0x40, size 2, `LATENCY` = 1 → `rsp_valid` in the next cycle with data 0xAABBCCDD. `misalign` stays 0.
- Write addr 0x41, size 0, data 0x0000EE00. Read at 0x40 in the next cycle → 0xAABBEEDD.
- Write addr 0x42, size 1, data 0x12340000, then a word read → 0x1234EEDD. Write addr 0x41, size 1 → `misalign` pulse in the next cycle, memory unchanged.
- `LATENCY` = 3, `DEPTH` = 2, back-to-back reads on consecutive cycles:
  - `ready` drops after the second acceptance.
  - Responses arrive in order on two consecutive cycles.
  - `ready` recovers in the cycle after the first pop.
- Two reads outstanding, then assert `reset` for 1 cycle → no `rsp_valid` afterward, `ready` = 1 after reset, and memory still reads back 0x1234EEDD.
- Read addr 0x1040 with `MEM_WORDS` = 256 → returns the same word as 0x0040 (alias).

Source files
------------

// File: rtl/rv_dmem_pkg.sv
// rv_dmem_pkg
// Shared types and helpers for the data-memory responder.
//   size_e      : request size encodings (byte / half / word / illegal)
//   rsp_entry_t : one response-queue slot {read word, countdown}
//   byte_mask   : lane enables for a request of a given size and offset
//   is_aligned  : true when the size/offset pair is a legal access
package rv_dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_e;

  // Countdown is wide enough for the largest legal latency (8).
  localparam int CD_W = 4;

  typedef struct packed {
    logic [31:0]     data;
    logic [CD_W-1:0] cd;
  } rsp_entry_t;

  function automatic logic [3:0] byte_mask(input size_e size, input logic [1:0] addr_lo);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001 << addr_lo;
      SZ_H:    m = 4'b0011 << addr_lo;
      SZ_W:    m = 4'b1111 << addr_lo;
      default: m = 4'b1111 << addr_lo;
    endcase
    return m;
  endfunction

  function automatic logic is_aligned(input size_e size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = !addr_lo[0];
      SZ_W:    ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rv_dmem_responder_if.sv
// rv_dmem_responder_if
// Core data port bundle between a requester (master) and the data memory
// (slave). Requests carry a byte address, size and lane-aligned write data;
// responses are single-cycle pulses with no back-pressure. misalign is a
// one-cycle error pulse raised by the memory for illegal accesses.
interface rv_dmem_responder_if;
  logic        data_req_valid;
  logic        data_req_ready;
  logic        data_req_wr;
  logic [31:0] data_req_addr;
  logic [1:0]  data_req_size;
  logic [31:0] data_req_data;
  logic        data_rsp_valid;
  logic [31:0] data_rsp_data;
  logic        misalign;

  modport master (
    output data_req_valid, data_req_wr, data_req_addr, data_req_size, data_req_data,
    input  data_req_ready, data_rsp_valid, data_rsp_data, misalign
  );

  modport slave (
    input  data_req_valid, data_req_wr, data_req_addr, data_req_size, data_req_data,
    output data_req_ready, data_rsp_valid, data_rsp_data, misalign
  );
endinterface

// File: rtl/rv_dmem_rsp_queue.sv
// rv_dmem_rsp_queue
// In-order read-response queue. Each pushed word carries a countdown that
// starts at LATENCY-1; the head is presented combinationally once its
// countdown is zero and pops at the next edge.
//   clk, reset : clock, synchronous active-high reset (drops all entries)
//   push       : enqueue push_data (caller guarantees !full)
//   push_data  : word sampled at acceptance
//   pop_valid  : head is due this cycle
//   pop_data   : head word
//   full       : DEPTH entries outstanding
module rv_dmem_rsp_queue
  import rv_dmem_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_data,
  output logic        pop_valid,
  output logic [31:0] pop_data,
  output logic        full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CD_W-1:0]  CD_INIT  = CD_W'(LATENCY - 1);

  rsp_entry_t       entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  assign full      = (count == CNT_W'(DEPTH));
  assign pop_valid = !reset && (count != '0) && (entries[head].cd == '0);
  assign pop_data  = entries[head].data;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= (tail == LAST_PTR) ? '0 : tail + 1'b1;
      if (pop_valid) head <= (head == LAST_PTR) ? '0 : head + 1'b1;
      if (push && !pop_valid) count <= count + 1'b1;
      else if (!push && pop_valid) count <= count - 1'b1;
    end
  end

  // Every slot ages each cycle; stale slots are never observed because
  // only the head of a non-empty queue is presented. The push targets a
  // free slot, so it never collides with a live entry's countdown.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].cd != '0) entries[i].cd <= entries[i].cd - 1'b1;
    end
    if (push && !reset) begin
      entries[tail].data <= push_data;
      entries[tail].cd   <= CD_INIT;
    end
  end

endmodule

// File: rtl/rv_dmem_responder.sv
// rv_dmem_responder
// Data-memory slave behind the core data port. Accepts one request per
// cycle, applies byte-masked writes to a word array, and returns full-word
// read data in order after a fixed LATENCY with up to DEPTH reads in flight.
//   clk   : clock
//   reset : synchronous active-high reset (memory contents are retained)
//   bus   : rv_dmem_responder_if.slave request/response/misalign bundle
module rv_dmem_responder
  import rv_dmem_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = 1,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  rv_dmem_responder_if.slave   bus
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [31:0]      mem [MEM_WORDS];
  logic [IDX_W-1:0] idx;
  size_e            size;
  logic [1:0]       addr_lo;
  logic [3:0]       mask;
  logic             legal;
  logic             accept;
  logic             q_full;
  logic             q_pop_valid;
  logic [31:0]      q_pop_data;
  logic [31:0]      last_data;
  logic             misalign_q;

  // Upper address bits alias onto the array by design.
  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, bus.data_req_addr[31:IDX_W+2]};

  assign idx     = bus.data_req_addr[2 +: IDX_W];
  assign addr_lo = bus.data_req_addr[1:0];
  assign size    = size_e'(bus.data_req_size);
  assign mask    = byte_mask(size, addr_lo);
  assign legal   = is_aligned(size, addr_lo);

  assign bus.data_req_ready = !reset && !q_full;
  assign accept             = bus.data_req_valid && bus.data_req_ready;

  // Legal writes update only the masked lanes; illegal writes are dropped.
  always_ff @(posedge clk) begin
    if (accept && bus.data_req_wr && legal) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) mem[idx][8*i +: 8] <= bus.data_req_data[8*i +: 8];
      end
    end
  end

  // Reads (legal or not) sample the word before any write this edge, so the
  // core always gets a response and never hangs on a misaligned load.
  rv_dmem_rsp_queue #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_rsp_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (accept && !bus.data_req_wr),
    .push_data (mem[idx]),
    .pop_valid (q_pop_valid),
    .pop_data  (q_pop_data),
    .full      (q_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
      last_data  <= '0;
    end else begin
      misalign_q <= accept && !legal;
      if (q_pop_valid) last_data <= q_pop_data;
    end
  end

  // Response data tracks the head while valid and holds otherwise.
  assign bus.data_rsp_valid = q_pop_valid;
  assign bus.data_rsp_data  = q_pop_valid ? q_pop_data : last_data;
  assign bus.misalign       = misalign_q;

endmodule

// File: tb/tb_rv_dmem_responder.sv
module tb_rv_dmem_responder;

  logic clk = 1'b0;
  logic reset1 = 1'b1;
  logic reset2 = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rv_dmem_responder_if b1 ();
  rv_dmem_responder_if b2 ();

  rv_dmem_responder #(.MEM_WORDS(256), .LATENCY(1), .DEPTH(2)) dut1 (
    .clk   (clk),
    .reset (reset1),
    .bus   (b1.slave)
  );

  rv_dmem_responder #(.MEM_WORDS(256), .LATENCY(3), .DEPTH(2)) dut2 (
    .clk   (clk),
    .reset (reset2),
    .bus   (b2.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set1(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                      input logic [31:0] data);
    b1.data_req_valid = 1'b1;
    b1.data_req_wr    = wr;
    b1.data_req_addr  = addr;
    b1.data_req_size  = size;
    b1.data_req_data  = data;
  endtask

  task automatic set2(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                      input logic [31:0] data);
    b2.data_req_valid = 1'b1;
    b2.data_req_wr    = wr;
    b2.data_req_addr  = addr;
    b2.data_req_size  = size;
    b2.data_req_data  = data;
  endtask

  // One accepted request on dut1, returning just after the accepting edge.
  task automatic req1(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                      input logic [31:0] data);
    set1(wr, addr, size, data);
    tick();
    b1.data_req_valid = 1'b0;
  endtask

  task automatic req2(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                      input logic [31:0] data);
    set2(wr, addr, size, data);
    tick();
    b2.data_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++; if (b1.data_req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", b1.data_req_ready); end
    n_cmp++; if (b1.data_rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", b1.data_rsp_valid); end
    n_cmp++; if (b1.data_rsp_data !== 32'h0) begin n_err++; $display("FAIL reset_rsp_data: got %h expected 00000000", b1.data_rsp_data); end
    n_cmp++; if (b1.misalign !== 1'b0) begin n_err++; $display("FAIL reset_misalign: got %b expected 0", b1.misalign); end
    n_cmp++; if (b2.data_req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready2: got %b expected 0", b2.data_req_ready); end
    reset1 = 1'b0;
    reset2 = 1'b0;
    #1;
    n_cmp++; if (b1.data_req_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b expected 1", b1.data_req_ready); end
    n_cmp++; if (b2.data_req_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready2: got %b expected 1", b2.data_req_ready); end
  endtask

  task automatic test_read_basic();
    req1(1'b1, 32'h40, 2'd2, 32'hAABBCCDD);
    n_cmp++; if (b1.data_rsp_valid !== 1'b0) begin n_err++; $display("FAIL write_no_rsp: got %b expected 0", b1.data_rsp_valid); end
    req1(1'b0, 32'h40, 2'd2, 32'h0);
    n_cmp++; if (b1.data_rsp_valid !== 1'b1) begin n_err++; $display("FAIL read_valid: got %b expected 1", b1.data_rsp_valid); end
    n_cmp++; if (b1.data_rsp_data !== 32'hAABBCCDD) begin n_err++; $display("FAIL read_data: got %h expected aabbccdd", b1.data_rsp_data); end
    n_cmp++; if (b1.misalign !== 1'b0) begin n_err++; $display("FAIL read_misalign: got %b expected 0", b1.misalign); end
    tick();
    n_cmp++; if (b1.data_rsp_valid !== 1'b0) begin n_err++; $display("FAIL read_pulse: got %b expected 0", b1.data_rsp_valid); end
    n_cmp++; if (b1.data_rsp_data !== 32'hAABBCCDD) begin n_err++; $display("FAIL read_hold: got %h expected aabbccdd", b1.data_rsp_data); end
    // Byte read returns the whole unshifted word.
    req1(1'b0, 32'h43, 2'd0, 32'h0);
    n_cmp++; if (b1.data_rsp_data !== 32'hAABBCCDD) begin n_err++; $display("FAIL byte_read_word: got %h expected aabbccdd", b1.data_rsp_data); end
  endtask

  task automatic test_partial_write();
    req1(1'b1, 32'h41, 2'd0, 32'h0000EE00);
    req1(1'b0, 32'h40, 2'd2, 32'h0);
    n_cmp++; if (b1.data_rsp_valid !== 1'b1 || b1.data_rsp_data !== 32'hAABBEEDD) begin n_err++; $display("FAIL byte_write: got %b/%h expected 1/aabbeedd", b1.data_rsp_valid, b1.data_rsp_data); end
    req1(1'b1, 32'h42, 2'd1, 32'h12340000);
    req1(1'b0, 32'h40, 2'd2, 32'h0);
    n_cmp++; if (b1.data_rsp_data !== 32'h1234EEDD) begin n_err++; $display("FAIL half_write: got %h expected 1234eedd", b1.data_rsp_data); end
  endtask

  task automatic test_misalign();
    req1(1'b1, 32'h41, 2'd1, 32'hFFFFFFFF);
    n_cmp++; if (b1.misalign !== 1'b1) begin n_err++; $display("FAIL misalign_half: got %b expected 1", b1.misalign); end
    tick();
    n_cmp++; if (b1.misalign !== 1'b0) begin n_err++; $display("FAIL misalign_pulse: got %b expected 0", b1.misalign); end
    req1(1'b1, 32'h42, 2'd2, 32'hFFFFFFFF);
    n_cmp++; if (b1.misalign !== 1'b1) begin n_err++; $display("FAIL misalign_word: got %b expected 1", b1.misalign); end
    req1(1'b1, 32'h40, 2'd3, 32'hFFFFFFFF);
    n_cmp++; if (b1.misalign !== 1'b1) begin n_err++; $display("FAIL misalign_size3_wr: got %b expected 1", b1.misalign); end
    // Illegal read still responds, with the unchanged word.
    req1(1'b0, 32'h40, 2'd3, 32'h0);
    n_cmp++; if (b1.misalign !== 1'b1) begin n_err++; $display("FAIL misalign_size3_rd: got %b expected 1", b1.misalign); end
    n_cmp++; if (b1.data_rsp_valid !== 1'b1 || b1.data_rsp_data !== 32'h1234EEDD) begin n_err++; $display("FAIL misalign_rd_rsp: got %b/%h expected 1/1234eedd", b1.data_rsp_valid, b1.data_rsp_data); end
    req1(1'b0, 32'h40, 2'd2, 32'h0);
    n_cmp++; if (b1.misalign !== 1'b0) begin n_err++; $display("FAIL legal_after_misalign: got %b expected 0", b1.misalign); end
    n_cmp++; if (b1.data_rsp_data !== 32'h1234EEDD) begin n_err++; $display("FAIL mem_unchanged: got %h expected 1234eedd", b1.data_rsp_data); end
  endtask

  task automatic test_alias();
    req1(1'b0, 32'h1040, 2'd2, 32'h0);
    n_cmp++; if (b1.data_rsp_valid !== 1'b1 || b1.data_rsp_data !== 32'h1234EEDD) begin n_err++; $display("FAIL alias: got %b/%h expected 1/1234eedd", b1.data_rsp_valid, b1.data_rsp_data); end
  endtask

  task automatic test_back_to_back();
    req2(1'b1, 32'h40, 2'd2, 32'h11223344);
    req2(1'b1, 32'h44, 2'd2, 32'h55667788);
    set2(1'b0, 32'h40, 2'd2, 32'h0);
    n_cmp++; if (b2.data_req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready0: got %b expected 1", b2.data_req_ready); end
    tick();
    set2(1'b0, 32'h44, 2'd2, 32'h0);
    n_cmp++; if (b2.data_req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready1: got %b expected 1", b2.data_req_ready); end
    tick();
    b2.data_req_valid = 1'b0;
    n_cmp++; if (b2.data_req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full: got %b expected 0", b2.data_req_ready); end
    n_cmp++; if (b2.data_rsp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_early: got %b expected 0", b2.data_rsp_valid); end
    tick();
    n_cmp++; if (b2.data_rsp_valid !== 1'b1 || b2.data_rsp_data !== 32'h11223344) begin n_err++; $display("FAIL b2b_rsp0: got %b/%h expected 1/11223344", b2.data_rsp_valid, b2.data_rsp_data); end
    n_cmp++; if (b2.data_req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_still_full: got %b expected 0", b2.data_req_ready); end
    tick();
    n_cmp++; if (b2.data_rsp_valid !== 1'b1 || b2.data_rsp_data !== 32'h55667788) begin n_err++; $display("FAIL b2b_rsp1: got %b/%h expected 1/55667788", b2.data_rsp_valid, b2.data_rsp_data); end
    n_cmp++; if (b2.data_req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_recover: got %b expected 1", b2.data_req_ready); end
    tick();
    n_cmp++; if (b2.data_rsp_valid !== 1'b0 || b2.data_rsp_data !== 32'h55667788) begin n_err++; $display("FAIL b2b_hold: got %b/%h expected 0/55667788", b2.data_rsp_valid, b2.data_rsp_data); end
  endtask

  task automatic test_reset_mid();
    set2(1'b0, 32'h40, 2'd2, 32'h0);
    tick();
    set2(1'b0, 32'h44, 2'd2, 32'h0);
    tick();
    b2.data_req_valid = 1'b0;
    reset2 = 1'b1;
    tick();
    reset2 = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (b2.data_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_drop_%0d: got %b expected 0", i, b2.data_rsp_valid); end
      n_cmp++; if (b2.data_req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_%0d: got %b expected 1", i, b2.data_req_ready); end
      tick();
    end
    n_cmp++; if (b2.misalign !== 1'b0) begin n_err++; $display("FAIL rst_misalign: got %b expected 0", b2.misalign); end
    req2(1'b0, 32'h40, 2'd2, 32'h0);
    tick();
    n_cmp++; if (b2.data_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_read_early: got %b expected 0", b2.data_rsp_valid); end
    tick();
    n_cmp++; if (b2.data_rsp_valid !== 1'b1 || b2.data_rsp_data !== 32'h11223344) begin n_err++; $display("FAIL rst_mem_kept: got %b/%h expected 1/11223344", b2.data_rsp_valid, b2.data_rsp_data); end
  endtask

  task automatic test_reset_mid_l1();
    // Memory on dut1 survives a reset pulse as well.
    reset1 = 1'b1;
    tick();
    reset1 = 1'b0;
    #1;
    req1(1'b0, 32'h40, 2'd2, 32'h0);
    n_cmp++; if (b1.data_rsp_data !== 32'h1234EEDD) begin n_err++; $display("FAIL rst_mem_kept1: got %h expected 1234eedd", b1.data_rsp_data); end
  endtask

  initial begin
    b1.data_req_valid = 1'b0; b1.data_req_wr = 1'b0; b1.data_req_addr = '0;
    b1.data_req_size  = 2'd2; b1.data_req_data = '0;
    b2.data_req_valid = 1'b0; b2.data_req_wr = 1'b0; b2.data_req_addr = '0;
    b2.data_req_size  = 2'd2; b2.data_req_data = '0;
    test_reset();
    test_read_basic();
    test_partial_write();
    test_misalign();
    test_alias();
    test_back_to_back();
    test_reset_mid();
    test_reset_mid_l1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
